ship_motion_ctrl: RTL and testbench
===================================

Name: ship_motion_ctrl

Overview:
Parametrised successor to the player-ship locator. Moves the player ship from multi-slot keyboard input with diagonal motion and edge clamping. Adds a life/explosion/respawn state machine with invulnerability blink, and a rate-limited fire request. Sits between the keyboard interface and the sprite renderer/bullet spawner. All state updates once per frame_clk.

Parameters:
X_MIN, 0, leftmost legal ship X (pixels)
X_MAX, 639, rightmost visible pixel column
Y_MIN, 0, topmost legal ship Y
Y_MAX, 479, bottom visible pixel row
SHIP_W, 16, ship sprite width
SHIP_H, 16, ship sprite height
SPAWN_X, 312, X position on reset/respawn
SPAWN_Y, 440, Y position on reset/respawn
STEP, 2, pixels moved per frame per axis
LIVES, 3, initial lives (1..7)
EXPLODE_FRAMES, 32, frames spent in DYING
INVULN_FRAMES, 120, frames spent in RESPAWN
FIRE_COOLDOWN, 15, frames blocked after a fire
BLINK_SHIFT, 3, blink period bit index during RESPAWN
KEY_SLOTS, 2, number of 8-bit keycode slots

Ports:
Reset  in  1  asynchronous active-high reset
frame_clk  in  1  frame clock (vsync-derived)
keycode  in  8*KEY_SLOTS  concurrent USB HID keycodes; slot i = [8i+7:8i]
DrawX  in  10  current pixel X
DrawY  in  10  current pixel Y
ShipColl  in  1  collision with enemy/bullet, sampled at frame_clk
ShipOn  out  1  ship pixel visible at DrawX/DrawY
ShipDistX  out  10  DrawX-ShipX inside sprite box, else 0
ShipDistY  out  10  DrawY-ShipY inside sprite box, else 0
ShipX  out  10  ship top-left X
ShipY  out  10  ship top-left Y
FireReq  out  1  one-frame fire pulse to bullet spawner
ShipState  out  2  0 ALIVE, 1 DYING, 2 RESPAWN, 3 GAMEOVER
Lives  out  3  remaining lives

Behaviour:
- Reset: Reset, asynchronous, active-high; clock frame_clk.
- Reset values: ShipX=SPAWN_X, ShipY=SPAWN_Y, state ALIVE, Lives=LIVES, FireReq=0, cooldown=0, frame counter=0.
- Key decode: a key is held if any slot equals its code: W=0x1A, S=0x16, A=0x04, D=0x07, SPACE=0x2C. Code 0x00 is never a key.
- Direction: dx=+1 (D only), -1 (A only), 0 (neither or both). dy=-1 (W only), +1 (S only), 0 otherwise. Diagonals are allowed.
- Motion: movement is enabled in ALIVE and RESPAWN. The key is sampled and the position updated on the same edge (latency 1 frame).
- Next position uses 11-bit signed arithmetic: nx = X + dx*STEP, clamped to [X_MIN, X_MAX+1-SHIP_W]. ny is clamped the same way to [Y_MIN, Y_MAX+1-SHIP_H]. The clamped ship stays at the limit, with no bounce and no overshoot.
- State machine:
  - ALIVE: on ShipColl, go to DYING, Lives-1, counter=0, position frozen.
  - DYING: counter counts frames. At counter=EXPLODE_FRAMES-1, go to GAMEOVER if Lives==0. Otherwise go to RESPAWN, position=SPAWN, counter=0.
  - RESPAWN: ShipColl is ignored. At counter=INVULN_FRAMES-1, go to ALIVE.
  - GAMEOVER: terminal until Reset. No motion, no fire.
- Collision is sampled only at frame_clk edges. ShipColl held for several frames causes exactly one life loss.
- Fire: FireReq=1 for one frame when SPACE is held, cooldown==0, and state is ALIVE or RESPAWN. On that edge cooldown loads FIRE_COOLDOWN. Otherwise cooldown decrements to 0 and saturates there. Holding SPACE auto-fires with period FIRE_COOLDOWN+1 frames. Entering DYING forces FireReq=0 and clears cooldown.
- Render (combinational):
  - inbox = DrawX in [ShipX, ShipX+SHIP_W-1] and DrawY in [ShipY, ShipY+SHIP_H-1].
  - ShipOn = inbox & (ALIVE | DYING | (RESPAWN & ~counter[BLINK_SHIFT])). GAMEOVER gives ShipOn=0.
  - ShipDistX/Y are the offsets when inbox, else 0.
- Reset mid-DYING or mid-RESPAWN returns all state to reset values immediately.

Optional Feature:
SHIP_WRAP_X_EN
- Defined: horizontal motion wraps instead of clamping. nx < X_MIN gives X_MAX+1-SHIP_W; nx > X_MAX+1-SHIP_W gives X_MIN. Y still clamps.
- Undefined: both axes clamp.

Test Plan:
- Reset, hold D (0x07) for 200 frames -> ShipX increases by 2 per frame from 312, reaches 624, and stays at 624; ShipY stays 440.
- Slot0=0x1A, slot1=0x04 for 10 frames -> ShipX=292, ShipY=420. Slots 0x04+0x07 -> ShipX unchanged.
- Hold SPACE (0x2C) from frame 0 -> FireReq high at frames 0, 16, 32, and low on all other frames.
- Assert ShipColl for 5 frames in ALIVE -> Lives 3→2 once, ShipState=1 for 32 frames, then 2 with ShipX/Y=312/440. ShipOn blinks in 8-frame halves and ShipColl is ignored. After 120 frames ShipState=0.
- Three collisions separated by respawns -> Lives=0 and ShipState=3. Keys and SPACE have no effect and ShipOn=0. Reset restores Lives=3.
- With SHIP_WRAP_X_EN, ShipX=0 and A held 1 frame -> ShipX=624. Without it -> ShipX stays 0.

Source files
------------

// File: rtl/ship_motion_ctrl.sv
// Player ship controller: multi-slot key decode, diagonal motion with edge clamp, life/explode/respawn FSM, rate-limited fire.
// Optional build macro SHIP_WRAP_X_EN: horizontal motion wraps around the playfield instead of clamping.
module ship_motion_ctrl #(
    parameter int X_MIN          = 0,
    parameter int X_MAX          = 639,
    parameter int Y_MIN          = 0,
    parameter int Y_MAX          = 479,
    parameter int SHIP_W         = 16,
    parameter int SHIP_H         = 16,
    parameter int SPAWN_X        = 312,
    parameter int SPAWN_Y        = 440,
    parameter int STEP           = 2,
    parameter int LIVES          = 3,
    parameter int EXPLODE_FRAMES = 32,
    parameter int INVULN_FRAMES  = 120,
    parameter int FIRE_COOLDOWN  = 15,
    parameter int BLINK_SHIFT    = 3,
    parameter int KEY_SLOTS      = 2
) (
    input  logic                   Reset,
    input  logic                   frame_clk,
    input  logic [8*KEY_SLOTS-1:0] keycode,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    input  logic                   ShipColl,
    output logic                   ShipOn,
    output logic [9:0]             ShipDistX,
    output logic [9:0]             ShipDistY,
    output logic [9:0]             ShipX,
    output logic [9:0]             ShipY,
    output logic                   FireReq,
    output logic [1:0]             ShipState,
    output logic [2:0]             Lives
);
    localparam int CNT_MAX = (EXPLODE_FRAMES > INVULN_FRAMES) ? EXPLODE_FRAMES : INVULN_FRAMES;
    localparam int CNT_W0  = $clog2(CNT_MAX);
    localparam int CNT_W   = (CNT_W0 > BLINK_SHIFT) ? CNT_W0 : BLINK_SHIFT + 1;
    localparam int CD_W    = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;

    localparam logic signed [10:0] X_LO   = 11'(X_MIN);
    localparam logic signed [10:0] X_HI   = 11'(X_MAX + 1 - SHIP_W);
    localparam logic signed [10:0] Y_LO   = 11'(Y_MIN);
    localparam logic signed [10:0] Y_HI   = 11'(Y_MAX + 1 - SHIP_H);
    localparam logic signed [10:0] STEP_S = 11'(STEP);
    localparam logic [9:0]  X_LO_V   = 10'(X_MIN);
    localparam logic [9:0]  X_HI_V   = 10'(X_MAX + 1 - SHIP_W);
    localparam logic [9:0]  Y_LO_V   = 10'(Y_MIN);
    localparam logic [9:0]  Y_HI_V   = 10'(Y_MAX + 1 - SHIP_H);
    localparam logic [9:0]  SPAWN_XV = 10'(SPAWN_X);
    localparam logic [9:0]  SPAWN_YV = 10'(SPAWN_Y);
    localparam logic [10:0] SHIP_W_V = 11'(SHIP_W);
    localparam logic [10:0] SHIP_H_V = 11'(SHIP_H);
    localparam logic [2:0]  LIVES_V  = 3'(LIVES);
    localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(FIRE_COOLDOWN);
    localparam logic [CNT_W-1:0] EXP_LAST = CNT_W'(EXPLODE_FRAMES - 1);
    localparam logic [CNT_W-1:0] INV_LAST = CNT_W'(INVULN_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_ALIVE    = 2'd0,
        ST_DYING    = 2'd1,
        ST_RESPAWN  = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_t;

    state_t           state_q;
    logic [9:0]       x_q, y_q, x_d, y_d;
    logic [2:0]       lives_q;
    logic             fire_q;
    logic [CD_W-1:0]  cd_q;
    logic [CNT_W-1:0] cnt_q;

    logic key_w, key_s, key_a, key_d, key_fire;

    always_comb begin
        key_w    = 1'b0;
        key_s    = 1'b0;
        key_a    = 1'b0;
        key_d    = 1'b0;
        key_fire = 1'b0;
        for (int i = 0; i < KEY_SLOTS; i++) begin
            case (keycode[8*i +: 8])
                8'h1A:   key_w    = 1'b1;
                8'h16:   key_s    = 1'b1;
                8'h04:   key_a    = 1'b1;
                8'h07:   key_d    = 1'b1;
                8'h2C:   key_fire = 1'b1;
                default: ;
            endcase
        end
    end

    // Next position in signed 11 bits so a step below zero is visible before clamping.
    logic signed [10:0] x_s, y_s, nx, ny;

    always_comb begin
        x_s = {1'b0, x_q};
        y_s = {1'b0, y_q};
        nx  = x_s;
        ny  = y_s;
        if (key_d && !key_a)      nx = x_s + STEP_S;
        else if (key_a && !key_d) nx = x_s - STEP_S;
        if (key_s && !key_w)      ny = y_s + STEP_S;
        else if (key_w && !key_s) ny = y_s - STEP_S;
`ifdef SHIP_WRAP_X_EN
        if (nx < X_LO)      x_d = X_HI_V;
        else if (nx > X_HI) x_d = X_LO_V;
        else                x_d = nx[9:0];
`else
        if (nx < X_LO)      x_d = X_LO_V;
        else if (nx > X_HI) x_d = X_HI_V;
        else                x_d = nx[9:0];
`endif
        if (ny < Y_LO)      y_d = Y_LO_V;
        else if (ny > Y_HI) y_d = Y_HI_V;
        else                y_d = ny[9:0];
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_ALIVE;
            x_q     <= SPAWN_XV;
            y_q     <= SPAWN_YV;
            lives_q <= LIVES_V;
            fire_q  <= 1'b0;
            cd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            fire_q <= 1'b0;
            if (cd_q != '0) cd_q <= cd_q - 1'b1;
            case (state_q)
                ST_ALIVE: begin
                    if (ShipColl) begin
                        state_q <= ST_DYING;
                        lives_q <= lives_q - 3'd1;
                        cnt_q   <= '0;
                        cd_q    <= '0;
                    end else begin
                        x_q <= x_d;
                        y_q <= y_d;
                        if (key_fire && cd_q == '0) begin
                            fire_q <= 1'b1;
                            cd_q   <= CD_LOAD;
                        end
                    end
                end
                ST_DYING: begin
                    if (cnt_q == EXP_LAST) begin
                        cnt_q <= '0;
                        if (lives_q == 3'd0) begin
                            state_q <= ST_GAMEOVER;
                        end else begin
                            state_q <= ST_RESPAWN;
                            x_q     <= SPAWN_XV;
                            y_q     <= SPAWN_YV;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESPAWN: begin
                    x_q <= x_d;
                    y_q <= y_d;
                    if (key_fire && cd_q == '0) begin
                        fire_q <= 1'b1;
                        cd_q   <= CD_LOAD;
                    end
                    if (cnt_q == INV_LAST) begin
                        state_q <= ST_ALIVE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Unsigned 11-bit offsets: a pixel left of or above the ship fails the >= test first.
    logic [10:0] off_x, off_y;
    logic        inbox, visible;

    assign off_x = {1'b0, DrawX} - {1'b0, x_q};
    assign off_y = {1'b0, DrawY} - {1'b0, y_q};
    assign inbox = (DrawX >= x_q) && (off_x < SHIP_W_V) && (DrawY >= y_q) && (off_y < SHIP_H_V);

    always_comb begin
        case (state_q)
            ST_ALIVE, ST_DYING: visible = 1'b1;
            ST_RESPAWN:         visible = ~cnt_q[BLINK_SHIFT];
            default:            visible = 1'b0;
        endcase
    end

    assign ShipOn    = inbox & visible;
    assign ShipDistX = inbox ? off_x[9:0] : 10'd0;
    assign ShipDistY = inbox ? off_y[9:0] : 10'd0;
    assign ShipX     = x_q;
    assign ShipY     = y_q;
    assign FireReq   = fire_q;
    assign ShipState = state_q;
    assign Lives     = lives_q;
endmodule

// File: tb/tb_ship_motion_ctrl.sv
// Bench for ship_motion_ctrl: directed scenarios plus random frames checked against a frame-level behavioural model.
module tb_ship_motion_ctrl;
    logic        Reset, frame_clk;
    logic [15:0] keycode;
    logic [9:0]  DrawX, DrawY;
    logic        ShipColl;
    logic        ShipOn, FireReq;
    logic [9:0]  ShipDistX, ShipDistY, ShipX, ShipY;
    logic [1:0]  ShipState;
    logic [2:0]  Lives;

    ship_motion_ctrl dut (
        .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
        .DrawX(DrawX), .DrawY(DrawY), .ShipColl(ShipColl),
        .ShipOn(ShipOn), .ShipDistX(ShipDistX), .ShipDistY(ShipDistY),
        .ShipX(ShipX), .ShipY(ShipY), .FireReq(FireReq),
        .ShipState(ShipState), .Lives(Lives)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    localparam int XHI = 640 - 16;
    localparam int YHI = 480 - 16;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model: state 0 alive, 1 dying, 2 respawn, 3 game over; age = frames since entering the phase.
    int m_x, m_y, m_state, m_lives, m_fire, m_cool, m_age;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit held(input logic [15:0] kc, input int code);
        held = 1'b0;
        for (int i = 0; i < 2; i++)
            if (code != 0 && int'(kc[8*i +: 8]) == code) held = 1'b1;
    endfunction

    task automatic model_reset();
        m_x = 312; m_y = 440; m_state = 0; m_lives = 3;
        m_fire = 0; m_cool = 0; m_age = 0;
    endtask

    task automatic model_move(input int dx, input int dy);
        m_x = m_x + 2 * dx;
`ifdef SHIP_WRAP_X_EN
        if (m_x < 0) m_x = XHI;
        else if (m_x > XHI) m_x = 0;
`else
        if (m_x < 0) m_x = 0;
        else if (m_x > XHI) m_x = XHI;
`endif
        m_y = m_y + 2 * dy;
        if (m_y < 0) m_y = 0;
        else if (m_y > YHI) m_y = YHI;
    endtask

    task automatic model_step(input logic [15:0] kc, input bit coll);
        int dx, dy, old_cool;
        bit sp;
        dx = int'(held(kc, 'h07)) - int'(held(kc, 'h04));
        dy = int'(held(kc, 'h16)) - int'(held(kc, 'h1A));
        sp = held(kc, 'h2C);
        old_cool = m_cool;
        m_fire = 0;
        if (m_cool > 0) m_cool = m_cool - 1;
        case (m_state)
            0: begin
                if (coll) begin
                    m_state = 1; m_lives = m_lives - 1; m_age = 0; m_cool = 0;
                end else begin
                    model_move(dx, dy);
                    if (sp && old_cool == 0) begin m_fire = 1; m_cool = 15; end
                end
            end
            1: begin
                if (m_age == 31) begin
                    m_age = 0;
                    if (m_lives == 0) m_state = 3;
                    else begin m_state = 2; m_x = 312; m_y = 440; end
                end else m_age++;
            end
            2: begin
                model_move(dx, dy);
                if (sp && old_cool == 0) begin m_fire = 1; m_cool = 15; end
                if (m_age == 119) begin m_state = 0; m_age = 0; end
                else m_age++;
            end
            default: ;
        endcase
    endtask

    int  c_dx, c_dy;
    bit  c_in, c_on;
    always @(negedge frame_clk) begin
        if (chk_en) begin
            c_dx = int'(DrawX) - m_x;
            c_dy = int'(DrawY) - m_y;
            c_in = (c_dx >= 0) && (c_dx < 16) && (c_dy >= 0) && (c_dy < 16);
            c_on = c_in && (m_state == 0 || m_state == 1 || (m_state == 2 && ((m_age / 8) % 2) == 0));
            check("ShipX", ShipX, m_x);
            check("ShipY", ShipY, m_y);
            check("ShipState", ShipState, m_state);
            check("Lives", Lives, m_lives);
            check("FireReq", FireReq, m_fire);
            check("ShipOn", ShipOn, c_on);
            check("ShipDistX", ShipDistX, c_in ? c_dx : 0);
            check("ShipDistY", ShipDistY, c_in ? c_dy : 0);
        end
    end

    task automatic pick_draw();
        int v;
        if ($urandom_range(0, 1) == 1) begin
            v = m_x - 4 + int'($urandom_range(0, 23));
            DrawX = 10'((v < 0) ? 0 : v);
            v = m_y - 4 + int'($urandom_range(0, 23));
            DrawY = 10'((v < 0) ? 0 : v);
        end else begin
            DrawX = 10'($urandom_range(0, 639));
            DrawY = 10'($urandom_range(0, 479));
        end
    endtask

    task automatic frame(input logic [15:0] kc, input bit coll);
        keycode  = kc;
        ShipColl = coll;
        @(posedge frame_clk);
        #1;
        model_step(kc, coll);
        pick_draw();
    endtask

    task automatic do_reset();
        Reset = 1'b1; keycode = '0; ShipColl = 1'b0;
        model_reset();
        repeat (2) @(posedge frame_clk);
        #2 Reset = 1'b0;
    endtask

    function automatic logic [7:0] rand_key();
        case ($urandom_range(0, 7))
            1: rand_key = 8'h1A;
            2: rand_key = 8'h16;
            3: rand_key = 8'h04;
            4: rand_key = 8'h07;
            5: rand_key = 8'h2C;
            6: rand_key = 8'($urandom_range(0, 255));
            default: rand_key = 8'h00;
        endcase
    endfunction

    int n1, n2;

    initial begin
        Reset = 1'b1; keycode = '0; ShipColl = 1'b0; DrawX = '0; DrawY = '0;
        model_reset();
        #1 chk_en = 1'b1;
        repeat (2) @(posedge frame_clk);
        #2 Reset = 1'b0;
        check("rst_X", ShipX, 312);
        check("rst_Y", ShipY, 440);
        check("rst_state", ShipState, 0);
        check("rst_lives", Lives, 3);
        check("rst_fire", FireReq, 0);

        // Hold D: walks right to the clamp at 624 and stays.
        for (int i = 0; i < 200; i++) frame(16'h0007, 1'b0);
        check("d_clamp_X", ShipX, 624);
        check("d_clamp_Y", ShipY, 440);

        // W in slot 0, A in slot 1: diagonal up-left.
        do_reset();
        for (int i = 0; i < 10; i++) frame(16'h041A, 1'b0);
        check("diag_X", ShipX, 292);
        check("diag_Y", ShipY, 420);
        for (int i = 0; i < 5; i++) frame(16'h0704, 1'b0);
        check("ad_cancel_X", ShipX, 292);

        // Auto-fire period of 16 frames.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            frame(16'h002C, 1'b0);
            check("autofire", FireReq, (i % 16 == 0) ? 1 : 0);
        end

        // Collision held 5 frames: one life lost, 32 dying, 120 respawn frames.
        do_reset();
        for (int i = 0; i < 10; i++) frame(16'h0007, 1'b0);
        n1 = 0; n2 = 0;
        for (int i = 0; i < 200; i++) begin
            frame(16'h0000, (i < 5) || (i >= 40 && i < 60));
            if (i == 0) check("coll_lives", Lives, 2);
            if (i == 32) begin
                check("respawn_X", ShipX, 312);
                check("respawn_Y", ShipY, 440);
            end
            if (ShipState == 2'd1) n1++;
            if (ShipState == 2'd2) n2++;
        end
        check("dying_frames", n1, 32);
        check("respawn_frames", n2, 120);
        check("back_alive", ShipState, 0);
        check("lives_after", Lives, 2);

        // Two more deaths end the game.
        for (int k = 0; k < 2; k++) begin
            frame(16'h0000, 1'b1);
            for (int i = 0; i < 160; i++) frame(16'h0000, 1'b0);
        end
        check("gameover_state", ShipState, 3);
        check("gameover_lives", Lives, 0);
        for (int i = 0; i < 20; i++) begin
            frame(16'h2C1A, 1'b0);
            check("gameover_nofire", FireReq, 0);
        end
        check("gameover_X", ShipX, 312);
        DrawX = 10'd315; DrawY = 10'd443;
        #1 check("gameover_hidden", ShipOn, 0);
        do_reset();
        check("reset_lives", Lives, 3);
        check("reset_state", ShipState, 0);

        // Left edge: clamp or wrap depending on build.
        for (int i = 0; i < 156; i++) frame(16'h0004, 1'b0);
        check("left_edge_X", ShipX, 0);
        frame(16'h0004, 1'b0);
`ifdef SHIP_WRAP_X_EN
        check("wrap_X", ShipX, 624);
`else
        check("clamp_X", ShipX, 0);
`endif

        // Random frames against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1499) == 0) do_reset();
            else frame({rand_key(), rand_key()}, $urandom_range(0, 39) == 0);
        end

        @(negedge frame_clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
